// File: rtl/exec_pkg.sv
// Shared types for the execute stage: ALU opcodes, ARM condition codes,
// NZCV bit positions, multiplier state encoding and the condition check.
package exec_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_ORR = 3'b011,
    ALU_MUL = 3'b100,
    ALU_MOV = 3'b101
  } alu_op_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [1:0] mul_state_t;
  localparam mul_state_t MUL_IDLE = 2'd0;
  localparam mul_state_t MUL_BUSY = 2'd1;
  localparam mul_state_t MUL_DONE = 2'd2;

  // ARM condition evaluation against an NZCV value; 1111 never executes
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
    case (cond)
      COND_EQ: cond_holds = z;
      COND_NE: cond_holds = !z;
      COND_CS: cond_holds = c;
      COND_CC: cond_holds = !c;
      COND_MI: cond_holds = n;
      COND_PL: cond_holds = !n;
      COND_VS: cond_holds = v;
      COND_VC: cond_holds = !v;
      COND_HI: cond_holds = c && !z;
      COND_LS: cond_holds = !c || z;
      COND_GE: cond_holds = (n == v);
      COND_LT: cond_holds = (n != v);
      COND_GT: cond_holds = !z && (n == v);
      COND_LE: cond_holds = z || (n != v);
      COND_AL: cond_holds = 1'b1;
      default: cond_holds = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exec_if.sv
// Execute-stage bus: decode-side E inputs, flow control, and the EX/MEM outputs.
//
// Flow control: stallE is the only handshake. While stallE is high the
// producer (F/D/E) holds every E-side input stable, and the M-side control
// outputs carry a bubble. flushE may change at any time and always wins.
interface exec_if import exec_pkg::*; #(parameter int WIDTH = 32) ();

  logic [WIDTH-1:0] SrcAE, SrcBE, WriteDataE, WA3E;
  alu_op_t          ALUControlE;
  logic [3:0]       CondE;
  logic [1:0]       FlagWriteE;
  logic             RegWriteE, MemWriteE, MemToRegE, PCSrcE, BranchE, PlusOneE;
  logic             flushE;

  logic             stallE, BranchTakenE;
  logic [3:0]       FlagsOut;
  logic [WIDTH-1:0] ALUResultM, WriteDataM, WA3M;
  logic             RegWriteM, MemWriteM, MemToRegM, PCSrcM, PlusOneM;
  mul_state_t       mul_state;

  modport master (
    output SrcAE, SrcBE, WriteDataE, WA3E, ALUControlE, CondE, FlagWriteE,
           RegWriteE, MemWriteE, MemToRegE, PCSrcE, BranchE, PlusOneE, flushE,
    input  stallE, BranchTakenE, FlagsOut, ALUResultM, WriteDataM, WA3M,
           RegWriteM, MemWriteM, MemToRegM, PCSrcM, PlusOneM, mul_state
  );

  modport slave (
    input  SrcAE, SrcBE, WriteDataE, WA3E, ALUControlE, CondE, FlagWriteE,
           RegWriteE, MemWriteE, MemToRegE, PCSrcE, BranchE, PlusOneE, flushE,
    output stallE, BranchTakenE, FlagsOut, ALUResultM, WriteDataM, WA3M,
           RegWriteM, MemWriteM, MemToRegM, PCSrcM, PlusOneM, mul_state
  );

endinterface

// File: rtl/exec_mul_seq.sv
// Iterative shift-add multiplier, MUL_STEP multiplier bits per cycle.
// IDLE -> BUSY (WIDTH/MUL_STEP cycles) -> DONE -> IDLE; abort returns to IDLE.
module exec_mul_seq import exec_pkg::*; #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output mul_state_t       state
);

  localparam int N  = WIDTH / MUL_STEP;
  localparam int CW = $clog2(N + 1);

  logic [WIDTH-1:0] mcand, mplier, acc, partial;
  logic [CW-1:0]    cnt;

  // Partial product for the low MUL_STEP multiplier bits
  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (mplier[j]) partial = partial + (mcand << j);
    end
  end

  // Sequencer and accumulator; only the low WIDTH product bits are kept
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= MUL_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start && !abort) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            state  <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          if (abort) begin
            state <= MUL_IDLE;
          end else begin
            acc    <= acc + partial;
            mcand  <= mcand << MUL_STEP;
            mplier <= mplier >> MUL_STEP;
            cnt    <= cnt + CW'(1);
            if (cnt == CW'(N - 1)) state <= MUL_DONE;
          end
        end
        MUL_DONE: state <= MUL_IDLE;
        default:  state <= MUL_IDLE;
      endcase
    end
  end

  assign busy    = (state == MUL_BUSY);
  assign done    = (state == MUL_DONE);
  assign product = acc;

endmodule

// File: rtl/execute_stage.sv
// ARM execute stage with EX/MEM pipeline register.
// ALU, condition check against the NZCV register, control gating.
// Optional iterative multiplier built when EXEC_MUL_EN is defined; otherwise
// MUL behaves as an undefined op and stallE is tied low.
module execute_stage import exec_pkg::*; #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 4
) (
  input  logic  clock,
  input  logic  reset,
  exec_if.slave bus
);

  if (WIDTH != 32 || (WIDTH % MUL_STEP) != 0) begin : g_cfg_check
    $error("execute_stage: WIDTH must be 32 and MUL_STEP must divide it");
  end

  logic [3:0]       nzcv;
  logic             cond_ex, live, stall, bubble;
  logic [WIDTH-1:0] result;
  logic [WIDTH:0]   wide;
  logic             c_out, v_out, is_arith;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign cond_ex = cond_holds(bus.CondE, nzcv);
  assign live    = cond_ex && !bus.flushE;

`ifdef EXEC_MUL_EN
  logic       mul_start, mul_busy;
  mul_state_t mul_state;

  assign mul_start = !reset && (bus.ALUControlE == ALU_MUL) && live && (mul_state == MUL_IDLE);

  exec_mul_seq #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .abort   (bus.flushE),
    .a       (bus.SrcAE),
    .b       (bus.SrcBE),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product),
    .state   (mul_state)
  );

  // Stall on the launch cycle and every BUSY cycle; a flush releases it at once
  assign stall         = mul_start || (mul_busy && !bus.flushE && !reset);
  assign bus.mul_state = mul_state;
`else
  assign stall         = 1'b0;
  assign mul_done      = 1'b0;
  assign mul_product   = '0;
  assign bus.mul_state = MUL_IDLE;
`endif

  assign bubble           = bus.flushE || stall;
  assign bus.stallE       = stall;
  assign bus.BranchTakenE = bus.BranchE && cond_ex && !bus.flushE;
  assign bus.FlagsOut     = nzcv;

  // ALU: ADD/SUB through a 33-bit sum so carry and NOT-borrow fall out directly
  always_comb begin
    result   = '0;
    wide     = '0;
    c_out    = nzcv[FLAG_C];
    v_out    = nzcv[FLAG_V];
    is_arith = 1'b0;
    case (bus.ALUControlE)
      ALU_ADD: begin
        wide     = {1'b0, bus.SrcAE} + {1'b0, bus.SrcBE};
        result   = wide[WIDTH-1:0];
        c_out    = wide[WIDTH];
        v_out    = (bus.SrcAE[WIDTH-1] == bus.SrcBE[WIDTH-1]) && (result[WIDTH-1] != bus.SrcAE[WIDTH-1]);
        is_arith = 1'b1;
      end
      ALU_SUB: begin
        wide     = {1'b0, bus.SrcAE} + {1'b0, ~bus.SrcBE} + {{WIDTH{1'b0}}, 1'b1};
        result   = wide[WIDTH-1:0];
        c_out    = wide[WIDTH];
        v_out    = (bus.SrcAE[WIDTH-1] != bus.SrcBE[WIDTH-1]) && (result[WIDTH-1] != bus.SrcAE[WIDTH-1]);
        is_arith = 1'b1;
      end
      ALU_AND: result = bus.SrcAE & bus.SrcBE;
      ALU_ORR: result = bus.SrcAE | bus.SrcBE;
      ALU_MUL: result = mul_done ? mul_product : '0;
      ALU_MOV: result = bus.SrcBE;
      default: result = '0;
    endcase
  end

  // NZCV register: written only by an executing, non-bubble instruction
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nzcv <= 4'b0000;
    end else if (live && !stall) begin
      if (bus.FlagWriteE[1]) begin
        nzcv[FLAG_N] <= result[WIDTH-1];
        nzcv[FLAG_Z] <= (result == '0);
      end
      if (bus.FlagWriteE[0] && is_arith) begin
        nzcv[FLAG_C] <= c_out;
        nzcv[FLAG_V] <= v_out;
      end
    end
  end

  // EX/MEM register: data always captured, controls gated or bubbled
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.ALUResultM <= '0;
      bus.WriteDataM <= '0;
      bus.WA3M       <= '0;
      bus.RegWriteM  <= 1'b0;
      bus.MemWriteM  <= 1'b0;
      bus.MemToRegM  <= 1'b0;
      bus.PCSrcM     <= 1'b0;
      bus.PlusOneM   <= 1'b0;
    end else begin
      bus.ALUResultM <= result;
      bus.WriteDataM <= bus.WriteDataE;
      bus.WA3M       <= bus.WA3E;
      if (bubble) begin
        bus.RegWriteM <= 1'b0;
        bus.MemWriteM <= 1'b0;
        bus.MemToRegM <= 1'b0;
        bus.PCSrcM    <= 1'b0;
        bus.PlusOneM  <= 1'b0;
      end else begin
        bus.RegWriteM <= bus.RegWriteE && live;
        bus.MemWriteM <= bus.MemWriteE && live;
        bus.MemToRegM <= bus.MemToRegE;
        bus.PCSrcM    <= bus.PCSrcE && live;
        bus.PlusOneM  <= bus.PlusOneE;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed ARM-flag/branch/multiply cases followed by
// randomized instructions checked against an arithmetic reference model.
module tb_execute_stage;
  import exec_pkg::*;

  localparam int MUL_STEP = 4;
  localparam int NMUL     = 32 / MUL_STEP;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exec_if bus ();

  execute_stage #(.WIDTH(32), .MUL_STEP(MUL_STEP)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [3:0]  m_nzcv = 4'b0000;
  int          m_age  = 0;   // 0 idle, 1..NMUL multiplying, NMUL+1 result ready
  logic        last_stall, last_br;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic cond_true(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // driver: ctl = {RegWrite, MemWrite, MemToReg, PCSrc, Branch, PlusOne}
  task automatic set_ins(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] cc, input logic [1:0] fw, input logic [5:0] ctl,
                         input logic fl);
    bus.ALUControlE = alu_op_t'(op);
    bus.SrcAE       = a;
    bus.SrcBE       = b;
    bus.CondE       = cc;
    bus.FlagWriteE  = fw;
    bus.RegWriteE   = ctl[5];
    bus.MemWriteE   = ctl[4];
    bus.MemToRegE   = ctl[3];
    bus.PCSrcE      = ctl[2];
    bus.BranchE     = ctl[1];
    bus.PlusOneE    = ctl[0];
    bus.flushE      = fl;
    bus.WriteDataE  = $urandom;
    bus.WA3E        = {28'd0, 4'($urandom_range(0, 15))};
  endtask

  // one E cycle: predict, check combinational outputs, clock, check M side
  task automatic cycle();
    logic        c, live, stall_e, done_e, bub;
    logic [2:0]  op;
    logic [31:0] a, b, res, wd, wa;
    logic [63:0] wide;
    logic [3:0]  nf;
    logic [4:0]  ctl_e;
    longint      s;
    int          sa, sb, new_age;
    mul_state_t  st_e;
    #1;
    op = bus.ALUControlE;
    a  = bus.SrcAE;
    b  = bus.SrcBE;
    sa = a;
    sb = b;
    c    = cond_true(bus.CondE, m_nzcv);
    live = c && !bus.flushE;
    stall_e = 1'b0; done_e = 1'b0; new_age = 0;
    if (m_age >= 1 && bus.flushE) new_age = 0;
    else if (m_age == NMUL + 1) done_e = 1'b1;
    else if (m_age >= 1) begin stall_e = 1'b1; new_age = m_age + 1; end
`ifdef EXEC_MUL_EN
    else if (op == 3'd4 && live) begin stall_e = 1'b1; new_age = 1; end
`endif
    bub = bus.flushE || stall_e;
    case (op)
      3'd0: res = a + b;
      3'd1: res = a - b;
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: begin wide = {32'd0, a} * {32'd0, b}; res = done_e ? wide[31:0] : 32'd0; end
      3'd5: res = b;
      default: res = 32'd0;
    endcase
    nf = m_nzcv;
    if (!bub && live) begin
      if (bus.FlagWriteE[1]) begin nf[3] = res[31]; nf[2] = (res == 32'd0); end
      if (bus.FlagWriteE[0] && op == 3'd0) begin
        wide  = {32'd0, a} + {32'd0, b};
        nf[1] = wide[32];
        s     = longint'(sa) + longint'(sb);
        nf[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      if (bus.FlagWriteE[0] && op == 3'd1) begin
        nf[1] = (a >= b);
        s     = longint'(sa) - longint'(sb);
        nf[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
    end
    ctl_e = {!bub && live && bus.RegWriteE, !bub && live && bus.MemWriteE, !bub && bus.MemToRegE,
             !bub && live && bus.PCSrcE, !bub && bus.PlusOneE};
    last_stall = bus.stallE;
    last_br    = bus.BranchTakenE;
    check("stallE", bus.stallE, stall_e);
    check("BranchTakenE", bus.BranchTakenE, bus.BranchE && c && !bus.flushE);
    exp_q.push_back(res);
    wd = bus.WriteDataE;
    wa = bus.WA3E;
    st_e = (new_age == 0) ? MUL_IDLE : (new_age <= NMUL) ? MUL_BUSY : MUL_DONE;
    @(posedge clk);
    #1;
    m_nzcv = nf;
    m_age  = new_age;
    check("ALUResultM", bus.ALUResultM, exp_q.pop_front());
    check("WriteDataM", bus.WriteDataM, wd);
    check("WA3M", bus.WA3M, wa);
    check("ctrlM", {bus.RegWriteM, bus.MemWriteM, bus.MemToRegM, bus.PCSrcM, bus.PlusOneM}, ctl_e);
    check("FlagsOut", bus.FlagsOut, m_nzcv);
`ifdef EXEC_MUL_EN
    check("mul_state", bus.mul_state, st_e);
`endif
    @(negedge clk);
  endtask

  // asynchronous reset: outputs must clear without waiting for a clock edge
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_ALUResultM", bus.ALUResultM, 32'd0);
    check("rst_WriteDataM", bus.WriteDataM, 32'd0);
    check("rst_WA3M", bus.WA3M, 32'd0);
    check("rst_ctrlM", {bus.RegWriteM, bus.MemWriteM, bus.MemToRegM, bus.PCSrcM, bus.PlusOneM}, 5'd0);
    check("rst_FlagsOut", bus.FlagsOut, 4'b0000);
    check("rst_stallE", bus.stallE, 1'b0);
    check("rst_mul_state", bus.mul_state, MUL_IDLE);
    m_nzcv = 4'b0000;
    m_age  = 0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] edge_vals[5] = '{32'h0, 32'h1, 32'h7fffffff, 32'h80000000, 32'hffffffff};

  function automatic logic [31:0] pick_operand(input int mode);
    case (mode)
      0: return $urandom;
      1: return edge_vals[$urandom_range(0, 4)];
      default: return 32'($urandom_range(0, 20));
    endcase
  endfunction

  initial begin
    int stalls;
    logic [31:0] a;
    set_ins(3'd0, 32'd0, 32'd0, 4'hE, 2'b00, 6'd0, 1'b0);
    @(negedge clk);
    do_reset();

    // signed overflow on ADD
    set_ins(3'd0, 32'h7fffffff, 32'h00000001, 4'hE, 2'b11, 6'b100000, 1'b0);
    cycle();
    check("add_ovf_result", bus.ALUResultM, 32'h80000000);
    check("add_ovf_flags", bus.FlagsOut, 4'b1001);

    // SUB equal operands: Z and C (no borrow)
    set_ins(3'd1, 32'd5, 32'd5, 4'hE, 2'b11, 6'b100000, 1'b0);
    cycle();
    check("sub_eq_flags", bus.FlagsOut, 4'b0110);
    set_ins(3'd5, 32'd0, 32'h100, 4'h0, 2'b00, 6'b000110, 1'b0);
    cycle();
    check("beq_taken", last_br, 1'b1);
    check("beq_pcsrc", bus.PCSrcM, 1'b1);

    // failed EQ: writes squashed, flags held
    set_ins(3'd0, 32'd1, 32'd1, 4'hE, 2'b11, 6'b000000, 1'b0);
    cycle();
    set_ins(3'd0, 32'd0, 32'd0, 4'h0, 2'b11, 6'b110000, 1'b0);
    cycle();
    check("eq_fail_writes", {bus.RegWriteM, bus.MemWriteM}, 2'b00);
    check("eq_fail_flags", bus.FlagsOut, 4'b0000);

`ifdef EXEC_MUL_EN
    // full multiply: N+1 stall cycles then the product
    set_ins(3'd4, 32'h00001234, 32'h00000010, 4'hE, 2'b00, 6'b100000, 1'b0);
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (last_stall) stalls++;
      else break;
    end
    check("mul_stall_cycles", stalls, NMUL + 1);
    check("mul_result", bus.ALUResultM, 32'h00012340);
    check("mul_regwrite", bus.RegWriteM, 1'b1);

    // flush on the third BUSY cycle aborts the multiply
    set_ins(3'd4, 32'h00001234, 32'h00000010, 4'hE, 2'b00, 6'b100000, 1'b0);
    cycle();
    cycle();
    cycle();
    bus.flushE = 1'b1;
    cycle();
    check("mul_flush_stall", last_stall, 1'b0);
    check("mul_flush_regwrite", bus.RegWriteM, 1'b0);
    check("mul_flush_state", bus.mul_state, MUL_IDLE);
`else
    set_ins(3'd4, 32'h00001234, 32'h00000010, 4'hE, 2'b00, 6'b100000, 1'b0);
    cycle();
    check("mul_off_stall", last_stall, 1'b0);
    check("mul_off_result", bus.ALUResultM, 32'd0);
`endif

    // randomized instruction stream; inputs held while the stage stalls
    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset();
      if (m_age == 0) begin
        a = pick_operand($urandom_range(0, 2));
        set_ins(3'($urandom_range(0, 7)), a,
                ($urandom_range(0, 3) == 0) ? a : pick_operand($urandom_range(0, 2)),
                4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                6'($urandom_range(0, 63)), $urandom_range(0, 9) == 0);
      end else begin
        bus.flushE = ($urandom_range(0, 11) == 0);
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
